// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer
//
// Moore control FSM for a shift-add multiplier datapath. A start request
// loads the operands and clears the accumulator. The FSM then runs WIDTH
// iterations of TEST -> (ADD) -> SHIFT, branching on the multiplier LSB that
// the datapath reports. At the end it latches the product and raises a
// one-cycle done pulse.
//
// Every control output is a register. Each one is loaded from a decode of
// the next state, so it always matches the registered state, and there is
// no combinational path from start or flag to any output.
//
// WIDTH : operand width in bits and number of iterations (legal 2..16).
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   multiply request, sampled only in IDLE
//   flag     in   multiplier LSB from datapath, sampled only in TEST
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse (DONE state)
//   en_a     out  load operand A register
//   en_b     out  load operand B register
//   ab_sel   out  shift-register source: 1 = B, 0 = ALU result
//   sr_ctrl  out  shift-register mode: 00 hold, 01 shift right, 10 load
//   en_sr    out  shift-register enable
//   alu_op   out  000 pass, 001 ACC + A
//   en_acc   out  accumulator write enable
//   clr_acc  out  synchronous accumulator clear
//   en_out   out  latch product into the output register
//   iter     out  remaining-iteration count (debug)
// ---------------------------------------------------------------------------
module mult_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       flag,
  output logic                       busy,
  output logic                       done,
  output logic                       en_a,
  output logic                       en_b,
  output logic                       ab_sel,
  output logic [1:0]                 sr_ctrl,
  output logic                       en_sr,
  output logic [2:0]                 alu_op,
  output logic                       en_acc,
  output logic                       clr_acc,
  output logic                       en_out,
  output logic [$clog2(WIDTH):0]     iter
);

  localparam int IW = $clog2(WIDTH) + 1;

  // Loaded into the counter in LOAD. The IW-bit field always holds WIDTH.
  localparam logic [IW-1:0] ITER_FULL = IW'(WIDTH);
  localparam logic [IW-1:0] ITER_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] ITER_ONE  = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_STORE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Complete set of control outputs, registered as one word.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en_a;
    logic       en_b;
    logic       ab_sel;
    logic [1:0] sr_ctrl;
    logic       en_sr;
    logic [2:0] alu_op;
    logic       en_acc;
    logic       clr_acc;
    logic       en_out;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    busy: 1'b0, done: 1'b0, en_a: 1'b0, en_b: 1'b0, ab_sel: 1'b0,
    sr_ctrl: 2'b00, en_sr: 1'b0, alu_op: 3'b000, en_acc: 1'b0,
    clr_acc: 1'b0, en_out: 1'b0
  };

  // Moore decode: the strobes that belong to a given state.
  function automatic ctrl_t f_decode(input state_t s);
    ctrl_t c;
    c = CTRL_NONE;
    case (s)
      S_IDLE: begin
        c = CTRL_NONE;
      end
      S_LOAD: begin
        c.busy    = 1'b1;
        c.en_a    = 1'b1;
        c.en_b    = 1'b1;
        c.clr_acc = 1'b1;
        c.en_sr   = 1'b1;
        c.sr_ctrl = 2'b10;
        c.ab_sel  = 1'b1;
      end
      S_TEST: begin
        c.busy = 1'b1;
      end
      S_ADD: begin
        c.busy   = 1'b1;
        c.alu_op = 3'b001;
        c.en_acc = 1'b1;
      end
      S_SHIFT: begin
        c.busy    = 1'b1;
        c.en_sr   = 1'b1;
        c.sr_ctrl = 2'b01;
        c.ab_sel  = 1'b0;
      end
      S_STORE: begin
        c.busy   = 1'b1;
        c.en_out = 1'b1;
      end
      S_DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
      end
      default: begin
        c = CTRL_NONE;
      end
    endcase
    return c;
  endfunction

  state_t          r_state;
  logic [IW-1:0]   r_iter;
  ctrl_t           r_ctrl;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_iter_nxt;

  // Next-state and iteration-count logic. flag is read only in TEST, so an
  // unknown flag in any other state cannot reach the state register.
  always_comb begin
    w_state_nxt = r_state;
    w_iter_nxt  = r_iter;
    case (r_state)
      S_IDLE: begin
        w_iter_nxt = ITER_ZERO;
        if (start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_iter_nxt  = ITER_FULL;
        w_state_nxt = S_TEST;
      end
      S_TEST: begin
        if (flag) begin
          w_state_nxt = S_ADD;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_ADD: begin
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        // The counter only decrements from a non-zero value, so it can
        // never wrap around. A count of 1 marks the last pass.
        if (r_iter > ITER_ONE) begin
          w_iter_nxt  = r_iter - ITER_ONE;
          w_state_nxt = S_TEST;
        end else begin
          w_iter_nxt  = ITER_ZERO;
          w_state_nxt = S_STORE;
        end
      end
      S_STORE: begin
        w_iter_nxt  = ITER_ZERO;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_iter_nxt  = ITER_ZERO;
        w_state_nxt = S_IDLE;
      end
      default: begin
        // Recover from an illegal encoding without issuing any strobe.
        w_iter_nxt  = ITER_ZERO;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and output registers. The outputs are loaded with the
  // decode of the next state, so they line up with r_state every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_iter  <= ITER_ZERO;
      r_ctrl  <= CTRL_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_iter  <= w_iter_nxt;
      r_ctrl  <= f_decode(w_state_nxt);
    end
  end

  assign busy    = r_ctrl.busy;
  assign done    = r_ctrl.done;
  assign en_a    = r_ctrl.en_a;
  assign en_b    = r_ctrl.en_b;
  assign ab_sel  = r_ctrl.ab_sel;
  assign sr_ctrl = r_ctrl.sr_ctrl;
  assign en_sr   = r_ctrl.en_sr;
  assign alu_op  = r_ctrl.alu_op;
  assign en_acc  = r_ctrl.en_acc;
  assign clr_acc = r_ctrl.clr_acc;
  assign en_out  = r_ctrl.en_out;
  assign iter    = r_iter;

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Moore FSM that sequences the shift-add multiplier datapath.
- Accepts a start pulse and issues one-hot-per-cycle control strobes: operand load, accumulator clear/add, shift-register load/shift, output latch.
- Iterates WIDTH times, branching on the datapath's multiplier-LSB flag, then signals completion.
- Sits between the top-level pins and the multiplier datapath; it replaces ad-hoc control wiring with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits; equals the number of shift-add iterations; legal range 2..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- flag  input  1  current multiplier LSB from the datapath; sampled only in TEST.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle completion pulse, high in DONE.
- en_a  output  1  load operand A register.
- en_b  output  1  load operand B register.
- ab_sel  output  1  shift-register source: 1 selects B (multiplier), 0 selects ALU result.
- sr_ctrl  output  2  shift-register mode: 00 hold, 01 shift right, 10 parallel load, 11 unused (never driven).
- en_sr  output  1  shift-register enable.
- alu_op  output  3  000 pass, 001 add ACC+A; all other codes unused.
- en_acc  output  1  accumulator write enable.
- clr_acc  output  1  synchronous accumulator clear.
- en_out  output  1  latch product into the output register.
- iter  output  $clog2(WIDTH)+1  remaining-iteration count, for debug and verification.

Behaviour:
- States: IDLE, LOAD, TEST, ADD, SHIFT, STORE, DONE. State and iter are registered.
- All outputs are pure decode of the registered state; there is no combinational path from start or flag to any output.
- Reset (async, rst_n=0), effective immediately, including mid-operation:
  - state=IDLE, iter=0.
  - All outputs 0; sr_ctrl=00, alu_op=000.
  - An in-flight multiply is abandoned with no done pulse.
- IDLE: all strobes 0.
  - start=1 -> LOAD.
- LOAD (1 cycle): en_a=1, en_b=1, clr_acc=1, en_sr=1, sr_ctrl=10, ab_sel=1.
  - iter <= WIDTH.
  - -> TEST.
- TEST (1 cycle): all strobes 0.
  - flag=1 -> ADD; flag=0 -> SHIFT.
- ADD (1 cycle): alu_op=001, en_acc=1.
  - -> SHIFT.
- SHIFT (1 cycle): en_sr=1, sr_ctrl=01, ab_sel=0.
  - iter <= iter-1.
  - If iter==1 (the last iteration) -> STORE, else -> TEST.
- STORE (1 cycle): en_out=1.
  - -> DONE.
- DONE (1 cycle): done=1.
  - -> IDLE unconditionally; start is ignored here.
- Latency, with start sampled high at edge 0:
  - LOAD occupies cycle 1 and DONE occupies cycle 2*WIDTH+3+k, where k = number of 1-bits in the multiplier.
  - WIDTH=4: done in cycle 11 (B=0) through cycle 15 (B=0xF).
- start held high continuously: back-to-back operations. Each IDLE visit lasts exactly one cycle before the next LOAD.
- start pulses while busy=1 are ignored; they are not queued.
- flag is treated as don't-care outside TEST; X on flag outside TEST must not propagate to state.
- iter never underflows; iter is 0 in IDLE, STORE and DONE.
- Exactly one of {en_acc via ADD, en_sr via SHIFT, en_out, done, LOAD strobes} group is active per cycle. clr_acc and en_acc are never high together.

Test Plan:
- Reset mid-run: assert rst_n=0 while in ADD, async with no clock edge -> state=IDLE, all outputs 0 at once, no done pulse; after release, start runs normally.
- WIDTH=4, start 1 cycle, flag=0 every TEST -> sequence LOAD,(TEST,SHIFT)x4,STORE,DONE; done high only in cycle 11; en_acc never high.
- WIDTH=4, flag=1 every TEST -> 4 ADD cycles, each followed by SHIFT; done in cycle 15; iter sequence 4,3,2,1,0 observed after each SHIFT.
- Flag pattern 1,0,1,1 with the integrated datapath, A=0x7, B=0xD -> product 0x5B latched on en_out; done in cycle 14.
- start held high for 40 cycles -> consecutive operations separated by exactly one IDLE cycle; start pulses injected mid-operation produce no extra LOAD.
- WIDTH=8 build, B=0xA5 (k=4) -> done in cycle 23; iter width is 4 bits.
